stopwatch_ctl_lap: RTL and testbench
====================================

STOPWATCH_CTL_LAP -- requirements
Module: stopwatch_ctl_lap

Interface
REQ-001 Parameter LAP_DEPTH, default 4: number of lap slots; legal range 2..2^IDX_W.
REQ-002 Parameter IDX_W, default 2: width of the lap slot index.
REQ-003 Parameter LAP_WRAP, default 0: 0 = stop capturing when full; 1 = overwrite the oldest slot, ring style.
REQ-004 One clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 trig  input  1  start/stop request; one-cycle pulse, already debounced, sampled on clk rising edge.
REQ-008 split  input  1  lap/split/clear request; one-cycle pulse, already debounced, sampled on clk rising edge.
REQ-009 init_regs  output  1  high means time registers must be cleared.
REQ-010 count_enabled  output  1  high means the time counter advances.
REQ-011 split_hold  output  1  high means the displayed value is frozen while counting continues.
REQ-012 lap_wr_en  output  1  one-cycle strobe: store the current time into slot lap_wr_idx.
REQ-013 lap_wr_idx  output  IDX_W  target slot for lap_wr_en.
REQ-014 lap_count  output  IDX_W+1  number of valid laps; saturates at LAP_DEPTH.
REQ-015 lap_full  output  1  high when lap_count == LAP_DEPTH.

Function
REQ-016 The FSM SHALL have four states: IDLE, COUNTING, PAUSED and SPLIT; all outputs are registered.
REQ-017 Decoding: IDLE gives init=1 en=0 hold=0; COUNTING gives 0/1/0; PAUSED gives 0/0/0; SPLIT gives 0/1/1.
REQ-018 Latency: a pulse sampled at edge N is reflected in the outputs directly after edge N, with no further delay.
REQ-019 IDLE: trig -> COUNTING; split is ignored.
REQ-020 COUNTING: trig -> PAUSED; split -> SPLIT with a lap capture.
REQ-021 SPLIT: split -> COUNTING, releasing the hold with no capture; trig -> PAUSED, releasing the hold.
REQ-022 PAUSED: trig -> COUNTING; split -> IDLE, clearing lap_count, the write pointer and lap_full.
REQ-023 trig and split high together: trig has priority and split is discarded.
REQ-024 Lap capture: lap_wr_en is high for exactly the one cycle following the capturing edge, together with split_hold rising.
REQ-025 On capture, lap_wr_idx equals the write pointer.
REQ-026 After a capture, the write pointer increments and lap_count increments, saturating at LAP_DEPTH.
REQ-027 Full with LAP_WRAP=0: the COUNTING->SPLIT transition still occurs, but lap_wr_en stays 0 and the pointer and lap_count are unchanged.
REQ-028 Full with LAP_WRAP=1: capture proceeds; the pointer wraps from LAP_DEPTH-1 to 0; lap_count stays LAP_DEPTH.
REQ-029 In both modes, the write pointer also wraps from LAP_DEPTH-1 to 0 when LAP_DEPTH < 2^IDX_W.
REQ-030 lap_wr_idx holds its last value between strobes.
REQ-031 Leaving IDLE SHALL NOT clear the laps; only reset or the PAUSED+split transition clears them.

Reset
REQ-032 While reset is high, the block SHALL hold IDLE: init_regs=1, count_enabled=0, split_hold=0, lap_wr_en=0, lap_wr_idx=0, lap_count=0, lap_full=0.
REQ-033 Assertion acts immediately, without waiting for a clock edge, from any state, including SPLIT and mid-strobe.
REQ-034 After release, the first sampled trig SHALL move to COUNTING.

Verification
REQ-035 Reset, then trig, trig, trig (10 ns clock) -> states IDLE, COUNTING, PAUSED, COUNTING; init/en = 1/0, 0/1, 0/0, 0/1.
REQ-036 In COUNTING, pulse split -> lap_wr_en=1 for 1 cycle with lap_wr_idx=0, then split_hold=1, en=1, lap_count=1.
REQ-037 Second split -> hold=0, en=1 and no strobe.
REQ-038 LAP_WRAP=0, LAP_DEPTH=4: 5 laps -> strobes at idx 0,1,2,3 only; lap_full=1; lap_count=4; the 5th split still gives hold=1.
REQ-039 LAP_WRAP=1, LAP_DEPTH=4: 6 laps -> strobe idx sequence 0,1,2,3,0,1; lap_count=4.
REQ-040 In PAUSED with lap_count=3, pulse split -> IDLE: init=1, lap_count=0, lap_full=0; then trig and a lap -> idx 0.
REQ-041 Reset asserted mid-clock while in SPLIT -> all outputs reach reset values before the next edge.
REQ-042 trig and split together in COUNTING -> PAUSED, no strobe, lap_count unchanged.

Source files
------------

// File: rtl/stopwatch_ctl_lap.sv
// Stopwatch control FSM with lap capture: drives the time counter controls and
// hands out lap slot indices for an external lap memory.
module stopwatch_ctl_lap #(
  parameter int LAP_DEPTH = 4,
  parameter int IDX_W     = 2,
  parameter int LAP_WRAP  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig,
  input  logic             split,
  output logic             init_regs,
  output logic             count_enabled,
  output logic             split_hold,
  output logic             lap_wr_en,
  output logic [IDX_W-1:0] lap_wr_idx,
  output logic [IDX_W:0]   lap_count,
  output logic             lap_full
);

  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(LAP_DEPTH);
  localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(LAP_DEPTH - 1);
  localparam logic             WRAP_C  = (LAP_WRAP != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNTING,
    S_PAUSED,
    S_SPLIT
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W:0]   r_count;
  logic             r_full;
  logic             r_init;
  logic             r_en;
  logic             r_hold;
  logic             r_wr_en;
  logic [IDX_W-1:0] r_wr_idx;

  logic [IDX_W-1:0] w_ptr_next;
  logic [IDX_W:0]   w_count_inc;
  logic             w_can_capture;

  // Pointer wraps at the last slot even when the index space is larger.
  assign w_ptr_next    = (r_ptr == LAST_C) ? '0 : r_ptr + 1'b1;
  assign w_count_inc   = r_count + 1'b1;
  assign w_can_capture = !r_full || WRAP_C;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_init   <= 1'b1;
      r_en     <= 1'b0;
      r_hold   <= 1'b0;
      r_wr_en  <= 1'b0;
      r_wr_idx <= '0;
    end else begin
      r_wr_en <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (trig) begin
            r_state <= S_COUNTING;
            r_init  <= 1'b0;
            r_en    <= 1'b1;
            r_hold  <= 1'b0;
          end
        end
        S_COUNTING: begin
          // trig wins over a simultaneous split
          if (trig) begin
            r_state <= S_PAUSED;
            r_init  <= 1'b0;
            r_en    <= 1'b0;
            r_hold  <= 1'b0;
          end else if (split) begin
            r_state <= S_SPLIT;
            r_init  <= 1'b0;
            r_en    <= 1'b1;
            r_hold  <= 1'b1;
            if (w_can_capture) begin
              r_wr_en  <= 1'b1;
              r_wr_idx <= r_ptr;
              r_ptr    <= w_ptr_next;
              if (!r_full) begin
                r_count <= w_count_inc;
                r_full  <= (w_count_inc == DEPTH_C);
              end
            end
          end
        end
        S_SPLIT: begin
          if (trig) begin
            r_state <= S_PAUSED;
            r_init  <= 1'b0;
            r_en    <= 1'b0;
            r_hold  <= 1'b0;
          end else if (split) begin
            r_state <= S_COUNTING;
            r_init  <= 1'b0;
            r_en    <= 1'b1;
            r_hold  <= 1'b0;
          end
        end
        S_PAUSED: begin
          if (trig) begin
            r_state <= S_COUNTING;
            r_init  <= 1'b0;
            r_en    <= 1'b1;
            r_hold  <= 1'b0;
          end else if (split) begin
            // Clearing drops the lap bookkeeping but leaves lap_wr_idx as-is.
            r_state <= S_IDLE;
            r_init  <= 1'b1;
            r_en    <= 1'b0;
            r_hold  <= 1'b0;
            r_ptr   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_init  <= 1'b1;
          r_en    <= 1'b0;
          r_hold  <= 1'b0;
        end
      endcase
    end
  end

  assign init_regs     = r_init;
  assign count_enabled = r_en;
  assign split_hold    = r_hold;
  assign lap_wr_en     = r_wr_en;
  assign lap_wr_idx    = r_wr_idx;
  assign lap_count     = r_count;
  assign lap_full      = r_full;

endmodule

// File: tb/tb_stopwatch_ctl_lap.sv
// Directed bench: two instances (stop-when-full and ring mode) share stimulus
// and are checked against hand-computed vectors.
module tb_stopwatch_ctl_lap;

  logic       clk;
  logic       reset;
  logic       trig;
  logic       split;
  logic [1:0] init_q;
  logic [1:0] en_q;
  logic [1:0] hold_q;
  logic [1:0] wr_en_q;
  logic [1:0] idx_q [2];
  logic [2:0] cnt_q [2];
  logic [1:0] full_q;

  int tests_run;
  int tests_failed;

  stopwatch_ctl_lap #(.LAP_DEPTH(4), .IDX_W(2), .LAP_WRAP(0)) u_dut_stop (
    .clk          (clk),
    .reset        (reset),
    .trig         (trig),
    .split        (split),
    .init_regs    (init_q[0]),
    .count_enabled(en_q[0]),
    .split_hold   (hold_q[0]),
    .lap_wr_en    (wr_en_q[0]),
    .lap_wr_idx   (idx_q[0]),
    .lap_count    (cnt_q[0]),
    .lap_full     (full_q[0])
  );

  stopwatch_ctl_lap #(.LAP_DEPTH(4), .IDX_W(2), .LAP_WRAP(1)) u_dut_wrap (
    .clk          (clk),
    .reset        (reset),
    .trig         (trig),
    .split        (split),
    .init_regs    (init_q[1]),
    .count_enabled(en_q[1]),
    .split_hold   (hold_q[1]),
    .lap_wr_en    (wr_en_q[1]),
    .lap_wr_idx   (idx_q[1]),
    .lap_count    (cnt_q[1]),
    .lap_full     (full_q[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       t;
    logic       s;
    logic       init;
    logic       en;
    logic       hold;
    logic       wr_en;
    logic [1:0] idx;
    logic [2:0] cnt;
    logic       full;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_dut(input int d, input string tag, input logic init, input logic en,
                         input logic hold, input logic wr_en, input logic [1:0] idx,
                         input logic [2:0] cnt, input logic full);
    string p;
    p = $sformatf("%s/dut%0d", tag, d);
    chk({p, ".init_regs"}, int'(init_q[d]), int'(init));
    chk({p, ".count_enabled"}, int'(en_q[d]), int'(en));
    chk({p, ".split_hold"}, int'(hold_q[d]), int'(hold));
    chk({p, ".lap_wr_en"}, int'(wr_en_q[d]), int'(wr_en));
    chk({p, ".lap_wr_idx"}, int'(idx_q[d]), int'(idx));
    chk({p, ".lap_count"}, int'(cnt_q[d]), int'(cnt));
    chk({p, ".lap_full"}, int'(full_q[d]), int'(full));
  endtask

  // Called at a falling edge: apply pulses for one rising edge, return at the next falling edge.
  task automatic step(input logic t, input logic s);
    trig  = t;
    split = s;
    @(posedge clk);
    #1;
    trig  = 1'b0;
    split = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    trig  = 1'b0;
    split = 1'b0;
    reset = 1'b1;

    //            t  s  init en hold wr idx cnt full
    vecs[0]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0};  // IDLE -> COUNTING
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0};  // -> PAUSED
    vecs[2]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0};  // -> COUNTING
    vecs[3]  = '{0, 1, 0, 1, 1, 1, 0, 1, 0};  // lap 0 captured
    vecs[4]  = '{0, 0, 0, 1, 1, 0, 0, 1, 0};  // SPLIT holds, strobe gone
    vecs[5]  = '{0, 1, 0, 1, 0, 0, 0, 1, 0};  // release, no strobe
    vecs[6]  = '{0, 1, 0, 1, 1, 1, 1, 2, 0};  // lap 1
    vecs[7]  = '{0, 1, 0, 1, 0, 0, 1, 2, 0};
    vecs[8]  = '{1, 1, 0, 0, 0, 0, 1, 2, 0};  // both in COUNTING: trig wins
    vecs[9]  = '{0, 1, 1, 0, 0, 0, 1, 0, 0};  // PAUSED+split clears
    vecs[10] = '{0, 1, 1, 0, 0, 0, 1, 0, 0};  // split ignored in IDLE
    vecs[11] = '{1, 0, 0, 1, 0, 0, 1, 0, 0};
    vecs[12] = '{0, 1, 0, 1, 1, 1, 0, 1, 0};  // pointer restarted at 0
    vecs[13] = '{1, 0, 0, 0, 0, 0, 0, 1, 0};  // SPLIT -> PAUSED
    vecs[14] = '{1, 0, 0, 1, 0, 0, 0, 1, 0};
    vecs[15] = '{0, 1, 0, 1, 1, 1, 1, 2, 0};
    vecs[16] = '{0, 1, 0, 1, 0, 0, 1, 2, 0};
    vecs[17] = '{0, 1, 0, 1, 1, 1, 2, 3, 0};
    vecs[18] = '{1, 0, 0, 0, 0, 0, 2, 3, 0};  // PAUSED with 3 laps
    vecs[19] = '{0, 1, 1, 0, 0, 0, 2, 0, 0};  // clear
    vecs[20] = '{1, 0, 0, 1, 0, 0, 2, 0, 0};
    vecs[21] = '{0, 1, 0, 1, 1, 1, 0, 1, 0};  // first lap after clear -> idx 0
    vecs[22] = '{1, 1, 0, 0, 0, 0, 0, 1, 0};  // both in SPLIT: trig wins
    vecs[23] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[24] = '{1, 0, 0, 1, 0, 0, 0, 0, 0};  // COUNTING, empty

    #12;
    for (int d = 0; d < 2; d++) chk_dut(d, "reset_hold", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk_dut(d, "after_release", 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].t, vecs[i].s);
      $display("[TB] vec %0d trig=%0d split=%0d init=%0d en=%0d hold=%0d wr=%0d/%0d idx=%0d/%0d cnt=%0d/%0d",
               i, vecs[i].t, vecs[i].s, init_q[0], en_q[0], hold_q[0], wr_en_q[0], wr_en_q[1],
               idx_q[0], idx_q[1], cnt_q[0], cnt_q[1]);
      for (int d = 0; d < 2; d++)
        chk_dut(d, $sformatf("vec%0d", i), vecs[i].init, vecs[i].en, vecs[i].hold,
                vecs[i].wr_en, vecs[i].idx, vecs[i].cnt, vecs[i].full);
    end

    // Six laps from empty: stop mode saturates at 4, ring mode wraps the index.
    for (int k = 1; k <= 6; k++) begin
      logic [1:0] idx_stop;
      logic [1:0] idx_ring;
      logic [2:0] cnt_exp;
      idx_stop = (k <= 4) ? 2'(k - 1) : 2'd3;
      idx_ring = 2'((k - 1) % 4);
      cnt_exp  = (k <= 4) ? 3'(k) : 3'd4;
      step(0, 1);
      $display("[TB] lap %0d stop: wr=%0d idx=%0d cnt=%0d full=%0d | ring: wr=%0d idx=%0d cnt=%0d full=%0d",
               k, wr_en_q[0], idx_q[0], cnt_q[0], full_q[0], wr_en_q[1], idx_q[1], cnt_q[1], full_q[1]);
      chk_dut(0, $sformatf("lap%0d", k), 0, 1, 1, (k <= 4), idx_stop, cnt_exp, (k >= 4));
      chk_dut(1, $sformatf("lap%0d", k), 0, 1, 1, 1'b1, idx_ring, cnt_exp, (k >= 4));
      step(0, 1);
      chk_dut(0, $sformatf("lap%0d_rel", k), 0, 1, 0, 0, idx_stop, cnt_exp, (k >= 4));
      chk_dut(1, $sformatf("lap%0d_rel", k), 0, 1, 0, 0, idx_ring, cnt_exp, (k >= 4));
    end

    // Into SPLIT (ring instance mid-strobe), then reset between clock edges.
    step(0, 1);
    chk_dut(1, "pre_reset", 0, 1, 1, 1, 2'd2, 3'd4, 1);
    #2;
    reset = 1'b1;
    #1;
    $display("[TB] async reset: init=%0d/%0d hold=%0d/%0d wr=%0d/%0d cnt=%0d/%0d",
             init_q[0], init_q[1], hold_q[0], hold_q[1], wr_en_q[0], wr_en_q[1], cnt_q[0], cnt_q[1]);
    for (int d = 0; d < 2; d++) chk_dut(d, "async_reset", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 0);
    for (int d = 0; d < 2; d++) chk_dut(d, "first_trig", 0, 1, 0, 0, 0, 0, 0);
    step(0, 1);
    for (int d = 0; d < 2; d++) chk_dut(d, "lap_after_reset", 0, 1, 1, 1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
